fetch_unit: RTL and testbench

Instruction-fetch stage for the 9-bit pipeline. Holds the 8-bit PC, drives the instruction-memory address, and presents the fetched word to the IF/ID pipeline register. It also consumes the branch/jump redirect fields that the IF/ID register returns from ID, steers the PC, and generates that register's `flush`.

---
 rtl/baluga_pkg.sv | 24 ++
 rtl/pc_next.sv | 58 +++++
 rtl/fetch_unit.sv | 102 ++++++++++
 tb/tb_fetch_unit.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/baluga_pkg.sv
// ---------------------------------------------------------------------------
// baluga_pkg: shared widths, special instruction words and fetch states.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package baluga_pkg;

  localparam int PC_WIDTH    = 8;
  localparam int INSTR_WIDTH = 9;

  localparam logic [INSTR_WIDTH-1:0] NOP_INSTR  = 9'h000;
  localparam logic [INSTR_WIDTH-1:0] HALT_INSTR = 9'h1FF;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t S_BOOT     = 2'd0;
  localparam fetch_state_t S_RUN      = 2'd1;
  localparam fetch_state_t S_REDIRECT = 2'd2;
  localparam fetch_state_t S_HALT     = 2'd3;

endpackage

`default_nettype wire

// File: rtl/pc_next.sv
// ---------------------------------------------------------------------------
// pc_next: combinational redirect decode, next-PC select and PC adders.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pc_next
  import baluga_pkg::*;
#(
  parameter int                     PC_WIDTH    = baluga_pkg::PC_WIDTH,
  parameter int                     INSTR_WIDTH = baluga_pkg::INSTR_WIDTH,
  parameter logic [INSTR_WIDTH-1:0] HALT_INSTR  = baluga_pkg::HALT_INSTR
) (
  input  fetch_state_t             state,
  input  logic [PC_WIDTH-1:0]      pc,
  input  logic [PC_WIDTH-1:0]      id_pc,
  input  logic                     stall,
  input  logic [PC_WIDTH-1:0]      branch_value,
  input  logic                     branch_ctrl,
  input  logic [PC_WIDTH-1:0]      jump_value,
  input  logic                     jump_ctrl,
  input  logic [INSTR_WIDTH-1:0]   imem_data,
  output logic [PC_WIDTH-1:0]      next_pc,
  output logic                     redirect,
  output logic                     advance,
  output logic                     fetching,
  output logic                     halt_word
);

  logic jump_taken;
  logic branch_taken;
  logic ctrl_live;

  // Only a clean 1 counts as taken; unknown control from ID must not redirect.
  assign jump_taken   = (jump_ctrl === 1'b1);
  assign branch_taken = (branch_ctrl === 1'b1);
  assign ctrl_live    = (state == S_RUN) || (state == S_HALT);

  assign redirect  = ctrl_live && (jump_taken || branch_taken);
  assign fetching  = ((state == S_RUN) || (state == S_REDIRECT)) && !stall;
  assign halt_word = (imem_data == HALT_INSTR);
  assign advance   = redirect || (fetching && !halt_word);

  // Same-width add wraps mod 2^PC_WIDTH, which is the sign-extended offset add.
  always_comb begin
    next_pc = pc + {{(PC_WIDTH-1){1'b0}}, 1'b1};
    if (redirect) begin
      if (jump_taken) begin
        next_pc = jump_value;
      end else begin
        next_pc = id_pc + branch_value;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit: instruction-fetch stage holding PC, fetch state and counters.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_unit
  import baluga_pkg::*;
#(
  parameter int                     PC_WIDTH    = baluga_pkg::PC_WIDTH,
  parameter int                     INSTR_WIDTH = baluga_pkg::INSTR_WIDTH,
  parameter logic [PC_WIDTH-1:0]    RESET_PC    = 8'h00,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = baluga_pkg::NOP_INSTR,
  parameter logic [INSTR_WIDTH-1:0] HALT_INSTR  = baluga_pkg::HALT_INSTR
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   stall,
  input  logic [PC_WIDTH-1:0]    if_branch_value,
  input  logic                   if_branch_ctrl,
  input  logic [PC_WIDTH-1:0]    if_jump_value,
  input  logic                   if_jump_ctrl,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  output logic [PC_WIDTH-1:0]    imem_addr,
  output logic [INSTR_WIDTH-1:0] if_instruction,
  output logic                   flush,
  output logic [PC_WIDTH-1:0]    pc,
  output logic                   halted,
  output logic [15:0]            fetch_count
);

  fetch_state_t          state;
  logic [PC_WIDTH-1:0]   id_pc;
  logic [PC_WIDTH-1:0]   next_pc;
  logic                  redirect;
  logic                  advance;
  logic                  fetching;
  logic                  halt_word;

  pc_next #(
    .PC_WIDTH    (PC_WIDTH),
    .INSTR_WIDTH (INSTR_WIDTH),
    .HALT_INSTR  (HALT_INSTR)
  ) u_pc_next (
    .state        (state),
    .pc           (pc),
    .id_pc        (id_pc),
    .stall        (stall),
    .branch_value (if_branch_value),
    .branch_ctrl  (if_branch_ctrl),
    .jump_value   (if_jump_value),
    .jump_ctrl    (if_jump_ctrl),
    .imem_data    (imem_data),
    .next_pc      (next_pc),
    .redirect     (redirect),
    .advance      (advance),
    .fetching     (fetching),
    .halt_word    (halt_word)
  );

  assign imem_addr      = pc;
  assign flush          = redirect;
  assign halted         = (state == S_HALT);
  assign if_instruction = ((state == S_RUN) || (state == S_REDIRECT)) ? imem_data : NOP_INSTR;

  // The wrong-path word forwarded on a redirect cycle is killed, so it is not counted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc          <= RESET_PC;
      id_pc       <= RESET_PC;
      state       <= S_BOOT;
      fetch_count <= 16'd0;
    end else begin
      if (advance) begin
        pc    <= next_pc;
        id_pc <= pc;
      end
      if (fetching && !redirect) begin
        fetch_count <= fetch_count + 16'd1;
      end
      case (state)
        S_BOOT: state <= S_RUN;
        S_RUN, S_REDIRECT: begin
          if (redirect) begin
            state <= S_REDIRECT;
          end else if (fetching) begin
            state <= halt_word ? S_HALT : S_RUN;
          end
        end
        S_HALT: begin
          if (redirect) begin
            state <= S_REDIRECT;
          end
        end
        default: state <= S_BOOT;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit: directed vector table plus reset-during-redirect sequence.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic [7:0]  if_branch_value = 8'h00;
  logic        if_branch_ctrl = 1'b0;
  logic [7:0]  if_jump_value = 8'h00;
  logic        if_jump_ctrl = 1'b0;
  logic [8:0]  imem_data;
  logic [7:0]  imem_addr;
  logic [8:0]  if_instruction;
  logic        flush;
  logic [7:0]  pc;
  logic        halted;
  logic [15:0] fetch_count;

  int checks = 0;
  int failures = 0;

  fetch_unit dut (
    .clock           (clock),
    .reset           (reset),
    .stall           (stall),
    .if_branch_value (if_branch_value),
    .if_branch_ctrl  (if_branch_ctrl),
    .if_jump_value   (if_jump_value),
    .if_jump_ctrl    (if_jump_ctrl),
    .imem_data       (imem_data),
    .imem_addr       (imem_addr),
    .if_instruction  (if_instruction),
    .flush           (flush),
    .pc              (pc),
    .halted          (halted),
    .fetch_count     (fetch_count)
  );

  always #5 clock = ~clock;

  // Instruction memory: word at address A is A+1, except a HALT word at 8'h09.
  assign imem_data = (imem_addr == 8'h09) ? 9'h1FF : ({1'b0, imem_addr} + 9'd1);

  typedef struct {
    logic        jc;
    logic [7:0]  jv;
    logic        bc;
    logic [7:0]  bv;
    logic        st;
    logic        ex_flush;
    logic [8:0]  ex_instr;
    logic [7:0]  ex_pc;
    logic [15:0] ex_cnt;
    logic        ex_halted;
  } vec_t;

  localparam int NVEC = 31;
  vec_t vecs[NVEC];

  function automatic vec_t mk(input logic jc, input logic [7:0] jv, input logic bc,
                              input logic [7:0] bv, input logic st, input logic fl,
                              input logic [8:0] ins, input logic [7:0] p,
                              input logic [15:0] cnt, input logic h);
    vec_t v;
    v.jc = jc; v.jv = jv; v.bc = bc; v.bv = bv; v.st = st;
    v.ex_flush = fl; v.ex_instr = ins; v.ex_pc = p; v.ex_cnt = cnt; v.ex_halted = h;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [15:0] act,
                       input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=%h required=%h", name, idx, act, exp);
    end
  endtask

  initial begin
    //             jc   jv     bc    bv     st   flush instr   pc     cnt    halted
    vecs[0]  = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 9'h000, 8'h00, 16'd0,  1'b0);
    vecs[1]  = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 9'h001, 8'h01, 16'd1,  1'b0);
    vecs[2]  = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 9'h002, 8'h02, 16'd2,  1'b0);
    vecs[3]  = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 9'h003, 8'h03, 16'd3,  1'b0);
    vecs[4]  = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 9'h004, 8'h04, 16'd4,  1'b0);
    vecs[5]  = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 9'h005, 8'h05, 16'd5,  1'b0);
    vecs[6]  = mk(1'b1, 8'h40, 1'b0, 8'h00, 1'b0, 1'b1, 9'h006, 8'h40, 16'd5,  1'b0);
    vecs[7]  = mk(1'b1, 8'h40, 1'b0, 8'h00, 1'b0, 1'b0, 9'h041, 8'h41, 16'd6,  1'b0);
    vecs[8]  = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 9'h042, 8'h42, 16'd7,  1'b0);
    vecs[9]  = mk(1'b1, 8'h10, 1'b0, 8'h00, 1'b0, 1'b1, 9'h043, 8'h10, 16'd7,  1'b0);
    vecs[10] = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 9'h011, 8'h11, 16'd8,  1'b0);
    vecs[11] = mk(1'b0, 8'h00, 1'b1, 8'hFC, 1'b0, 1'b1, 9'h012, 8'h0C, 16'd8,  1'b0);
    vecs[12] = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 9'h00D, 8'h0D, 16'd9,  1'b0);
    vecs[13] = mk(1'b1, 8'hFE, 1'b0, 8'h00, 1'b0, 1'b1, 9'h00E, 8'hFE, 16'd9,  1'b0);
    vecs[14] = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 9'h0FF, 8'hFF, 16'd10, 1'b0);
    vecs[15] = mk(1'b0, 8'h00, 1'b1, 8'h05, 1'b0, 1'b1, 9'h100, 8'h03, 16'd10, 1'b0);
    vecs[16] = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 9'h004, 8'h04, 16'd11, 1'b0);
    vecs[17] = mk(1'b1, 8'h20, 1'b1, 8'h10, 1'b0, 1'b1, 9'h005, 8'h20, 16'd11, 1'b0);
    vecs[18] = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 9'h021, 8'h21, 16'd12, 1'b0);
    vecs[19] = mk(1'b0, 8'h00, 1'bx, 8'h30, 1'b0, 1'b0, 9'h022, 8'h22, 16'd13, 1'b0);
    vecs[20] = mk(1'b1, 8'h07, 1'b0, 8'h00, 1'b0, 1'b1, 9'h023, 8'h07, 16'd13, 1'b0);
    vecs[21] = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 9'h008, 8'h07, 16'd13, 1'b0);
    vecs[22] = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 9'h008, 8'h07, 16'd13, 1'b0);
    vecs[23] = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 9'h008, 8'h07, 16'd13, 1'b0);
    vecs[24] = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 9'h008, 8'h08, 16'd14, 1'b0);
    vecs[25] = mk(1'b1, 8'h09, 1'b0, 8'h00, 1'b1, 1'b1, 9'h009, 8'h09, 16'd14, 1'b0);
    vecs[26] = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 9'h1FF, 8'h09, 16'd15, 1'b1);
    vecs[27] = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 9'h000, 8'h09, 16'd15, 1'b1);
    vecs[28] = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 9'h000, 8'h09, 16'd15, 1'b1);
    vecs[29] = mk(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 9'h000, 8'h00, 16'd15, 1'b0);
    vecs[30] = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 9'h001, 8'h01, 16'd16, 1'b0);

    repeat (2) @(negedge clock);
    check("rst_pc", -1, {8'h00, pc}, 16'h0000);
    check("rst_cnt", -1, fetch_count, 16'd0);
    check("rst_flush", -1, {15'd0, flush}, 16'd0);
    check("rst_halted", -1, {15'd0, halted}, 16'd0);
    check("rst_instr", -1, {7'd0, if_instruction}, 16'h0000);
    reset = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      if_jump_ctrl    = vecs[i].jc;
      if_jump_value   = vecs[i].jv;
      if_branch_ctrl  = vecs[i].bc;
      if_branch_value = vecs[i].bv;
      stall           = vecs[i].st;
      #1;
      check("flush", i, {15'd0, flush}, {15'd0, vecs[i].ex_flush});
      check("instr", i, {7'd0, if_instruction}, {7'd0, vecs[i].ex_instr});
      check("imem_addr", i, {8'h00, imem_addr}, {8'h00, pc});
      @(posedge clock);
      #1;
      check("pc", i, {8'h00, pc}, {8'h00, vecs[i].ex_pc});
      check("fetch_count", i, fetch_count, vecs[i].ex_cnt);
      check("halted", i, {15'd0, halted}, {15'd0, vecs[i].ex_halted});
      @(negedge clock);
    end

    // Reset arriving while a jump is pending in REDIRECT must discard the target.
    if_jump_ctrl  = 1'b1;
    if_jump_value = 8'h55;
    if_branch_ctrl = 1'b0;
    stall = 1'b0;
    @(posedge clock);
    #1;
    check("redir_pc", 100, {8'h00, pc}, 16'h0055);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_pc", 100, {8'h00, pc}, 16'h0000);
    check("mid_rst_cnt", 100, fetch_count, 16'd0);
    check("mid_rst_flush", 100, {15'd0, flush}, 16'd0);
    check("mid_rst_halted", 100, {15'd0, halted}, 16'd0);
    check("mid_rst_instr", 100, {7'd0, if_instruction}, 16'h0000);
    if_jump_ctrl = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("boot_instr", 101, {7'd0, if_instruction}, 16'h0000);
    @(posedge clock);
    #1;
    check("boot_pc", 101, {8'h00, pc}, 16'h0000);
    @(posedge clock);
    #1;
    check("post_boot_pc", 102, {8'h00, pc}, 16'h0001);
    check("post_boot_cnt", 102, fetch_count, 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
